id_stage_pipe: RTL and testbench

- Parametrised RV32I/RV32E instruction-decode stage with a registered output.
- Sits between the fetch stage and the execute stage. Contains the register file, the control decoder and a full immediate generator (I/S/B/U/J formats).
- Uses valid/ready handshakes on both sides, a one-bubble load-use interlock, a pipeline flush, and an illegal-opcode flag.

---
 rtl/id_pkg.sv | 38 +++
 rtl/id_stage_pipe_if.sv | 32 +++
 rtl/id_decode.sv | 125 ++++++++++++
 rtl/id_stage_pipe.sv | 128 ++++++++++++
 tb/tb_id_stage_pipe.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage.
// Opcodes, control-word layout and mem_to_reg / jump codes.
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int CTRL_W         = 12;
    localparam int CTRL_MEM_READ  = 11;
    localparam int CTRL_MEM_WRITE = 10;
    localparam int CTRL_REG_WRITE = 9;
    localparam int CTRL_ALU_SRC   = 8;
    localparam int CTRL_M2R       = 6;
    localparam int CTRL_JUMP      = 4;
    localparam int CTRL_ALU_OP    = 0;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;
    localparam logic [1:0] M2R_IMM = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_BR   = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JALR = 2'b11;

    function automatic logic reg_ok(input logic [4:0] idx, input int n);
        return int'(idx) < n;
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = surrounding pipeline, slave = the decode stage.
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [11:0]     out_ctrl;
    logic [AW-1:0]   out_rd;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_ctrl, out_rd,
        input  out_rs1_data, out_rs2_data, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_ctrl, out_rd,
        output out_rs1_data, out_rs2_data, out_imm, out_illegal
    );
endinterface

// File: rtl/id_decode.sv
// Combinational control decoder and I/S/B/U/J immediate generator.
// Flags unknown opcodes and register indices outside the register file.
module id_decode
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl,
    output logic [XLEN-1:0]   imm,
    output logic              illegal,
    output logic              uses_rs1,
    output logic              uses_rs2
);
    logic [6:0]        opc;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm_i;
    logic [31:0]       imm_s;
    logic [31:0]       imm_b;
    logic [31:0]       imm_u;
    logic [31:0]       imm_j;
    logic [31:0]       imm32;
    logic [CTRL_W-1:0] c;
    logic              bad_opc;
    logic              bad_reg;

    assign opc    = inst[6:0];
    assign funct3 = inst[14:12];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    // Opcode decode into the raw control word and immediate.
    always_comb begin
        c                      = '0;
        c[CTRL_M2R +: 2]       = M2R_ALU;
        c[CTRL_JUMP +: 2]      = JMP_NONE;
        imm32                  = '0;
        bad_opc                = 1'b0;
        uses_rs1               = 1'b0;
        uses_rs2               = 1'b0;
        unique case (1'b1)
            (opc == OPC_LUI): begin
                imm32               = imm_u;
                c[CTRL_M2R +: 2]    = M2R_IMM;
                c[CTRL_REG_WRITE]   = 1'b1;
            end
            (opc == OPC_AUIPC): begin
                imm32               = imm_u;
                c[CTRL_ALU_SRC]     = 1'b1;
                c[CTRL_REG_WRITE]   = 1'b1;
            end
            (opc == OPC_JAL): begin
                imm32               = imm_j;
                c[CTRL_JUMP +: 2]   = JMP_JAL;
                c[CTRL_M2R +: 2]    = M2R_PC4;
                c[CTRL_REG_WRITE]   = 1'b1;
            end
            (opc == OPC_JALR): begin
                imm32               = imm_i;
                uses_rs1            = 1'b1;
                c[CTRL_JUMP +: 2]   = JMP_JALR;
                c[CTRL_M2R +: 2]    = M2R_PC4;
                c[CTRL_REG_WRITE]   = 1'b1;
            end
            (opc == OPC_BRANCH): begin
                imm32               = imm_b;
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
                c[CTRL_JUMP +: 2]   = JMP_BR;
                c[CTRL_ALU_OP +: 4] = {1'b0, funct3};
            end
            (opc == OPC_LOAD): begin
                imm32               = imm_i;
                uses_rs1            = 1'b1;
                c[CTRL_MEM_READ]    = 1'b1;
                c[CTRL_ALU_SRC]     = 1'b1;
                c[CTRL_M2R +: 2]    = M2R_MEM;
                c[CTRL_REG_WRITE]   = 1'b1;
            end
            (opc == OPC_STORE): begin
                imm32               = imm_s;
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
                c[CTRL_MEM_WRITE]   = 1'b1;
                c[CTRL_ALU_SRC]     = 1'b1;
            end
            (opc == OPC_OP_IMM): begin
                imm32               = imm_i;
                uses_rs1            = 1'b1;
                c[CTRL_ALU_SRC]     = 1'b1;
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_ALU_OP +: 4] =
                    {(funct3 == 3'b101) & inst[30], funct3};
            end
            (opc == OPC_OP): begin
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
                c[CTRL_REG_WRITE]   = 1'b1;
                c[CTRL_ALU_OP +: 4] = {inst[30], funct3};
            end
            default: bad_opc = 1'b1;
        endcase
    end

    assign bad_reg = (c[CTRL_REG_WRITE] && !reg_ok(rd, NUM_REGS))
                   || (uses_rs1 && !reg_ok(rs1, NUM_REGS))
                   || (uses_rs2 && !reg_ok(rs2, NUM_REGS));

    assign illegal = bad_opc | bad_reg;
    assign ctrl    = illegal ? '0 : c;
    assign imm     = XLEN'($signed(imm32));
endmodule

// File: rtl/id_stage_pipe.sv
// RV32I/RV32E decode stage: register file, decoder, output register.
// Define ID_BYPASS_EN to forward a same-cycle write-back into rs data.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    id_stage_pipe_if.slave  bus
);
    logic [XLEN-1:0]   rf [NUM_REGS];
    logic [AW-1:0]     rs1_idx;
    logic [AW-1:0]     rs2_idx;
    logic [AW-1:0]     rd_idx;
    logic [XLEN-1:0]   rs1_rf;
    logic [XLEN-1:0]   rs2_rf;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_illegal;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              hazard;
    logic              in_ready;
    logic              accept;

    logic              out_valid_q;
    logic [XLEN-1:0]   out_pc_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [AW-1:0]     out_rd_q;
    logic [XLEN-1:0]   out_rs1_q;
    logic [XLEN-1:0]   out_rs2_q;
    logic [XLEN-1:0]   out_imm_q;
    logic              out_illegal_q;

    id_decode #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .inst     (bus.in_inst),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .illegal  (dec_illegal),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign rs1_idx = bus.in_inst[15 +: AW];
    assign rs2_idx = bus.in_inst[20 +: AW];
    assign rd_idx  = bus.in_inst[7 +: AW];

    assign rs1_rf = (rs1_idx == '0) ? '0 : rf[rs1_idx];
    assign rs2_rf = (rs2_idx == '0) ? '0 : rf[rs2_idx];

`ifdef ID_BYPASS_EN
    assign rs1_val = (wb_we && wb_addr != '0 && wb_addr == rs1_idx)
                   ? wb_data : rs1_rf;
    assign rs2_val = (wb_we && wb_addr != '0 && wb_addr == rs2_idx)
                   ? wb_data : rs2_rf;
`else
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    // A load in the output register blocks a consumer of its rd.
    assign hazard = out_valid_q && out_ctrl_q[CTRL_MEM_READ]
                 && (out_rd_q != '0)
                 && ((uses_rs1 && out_rd_q == rs1_idx)
                  || (uses_rs2 && out_rd_q == rs2_idx));

    assign in_ready = reset && !flush
                   && (!out_valid_q || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

    // Register file: cleared on reset, x0 never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Output register: flush beats accept, accept beats drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_ctrl_q    <= '0;
            out_rd_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_imm_q     <= '0;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= bus.in_pc;
            out_ctrl_q    <= dec_ctrl;
            out_rd_q      <= rd_idx;
            out_rs1_q     <= rs1_val;
            out_rs2_q     <= rs2_val;
            out_imm_q     <= dec_imm;
            out_illegal_q <= dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_ctrl     = out_ctrl_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_rs1_data = out_rs1_q;
    assign bus.out_rs2_data = out_rs2_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_illegal  = out_illegal_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: RV32I instance plus an RV32E instance.
// Expected packets are queued at acceptance and checked on exit.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .AW(5)) bus ();
    id_stage_pipe_if #(.XLEN(32), .AW(4)) bus_e ();

    id_stage_pipe #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .bus     (bus.slave)
    );

    id_stage_pipe #(.XLEN(32), .NUM_REGS(16)) dut_e (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wb_we   (wb_we),
        .wb_addr (wb_addr[3:0]),
        .wb_data (wb_data),
        .bus     (bus_e.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] ctrl;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        ill;
    } pkt_t;

    pkt_t        q[$];
    pkt_t        mon_act;
    pkt_t        mon_exp;
    logic [31:0] mreg [32];
    int          total = 0;
    int          bad = 0;

    function automatic pkt_t mk(input logic [31:0] inst,
                                input logic [31:0] pc,
                                input logic [11:0] ctrl,
                                input logic [31:0] imm,
                                input logic ill);
        pkt_t p;
        p.pc   = pc;
        p.ctrl = ctrl;
        p.rd   = inst[11:7];
        p.rs1  = mreg[inst[19:15]];
        p.rs2  = mreg[inst[24:20]];
        p.imm  = imm;
        p.ill  = ill;
        return p;
    endfunction

    // Scoreboard: every packet leaving the stage is matched in order.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1
            && bus.out_ready === 1'b1) begin
            mon_act = {bus.out_pc, bus.out_ctrl, bus.out_rd,
                       bus.out_rs1_data, bus.out_rs2_data,
                       bus.out_imm, bus.out_illegal};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pkt got=%h want=none",
                         mon_act);
            end else begin
                mon_exp = q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL pkt pc=%h got=%h want=%h",
                             mon_exp.pc, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        if (a != 5'd0) mreg[a] = d;
    endtask

    task automatic drive(input logic [31:0] inst,
                         input logic [31:0] pc,
                         input logic [11:0] ctrl,
                         input logic [31:0] imm,
                         input logic ill);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout inst=%h got=0 want=1", inst);
        end else begin
            q.push_back(mk(inst, pc, ctrl, imm, ill));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        flush = 1'b0;
        wb_we = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b1;
        bus_e.in_valid = 1'b0;
        bus_e.in_inst = '0;
        bus_e.in_pc = '0;
        bus_e.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=0", bus.in_ready);
        end
        total++;
        if ({bus.out_pc, bus.out_ctrl, bus.out_imm,
             bus.out_rs1_data, bus.out_rs2_data,
             bus.out_rd, bus.out_illegal} !== '0) begin
            bad++;
            $display("FAIL rst_regs got=%h/%h/%h want=0",
                     bus.out_pc, bus.out_ctrl, bus.out_imm);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_ready got=%b want=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi;
        wb_write(5'd0, 32'hDEAD_BEEF);
        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h100);
        wb_write(5'd3, 32'h33);
        wb_write(5'd5, 32'h55);
        wb_write(5'd7, 32'h77);
        drive(32'hFFB00093, 32'h100, 12'h300, 32'hFFFF_FFFB, 1'b0);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd1) begin
            bad++;
            $display("FAIL addi_out got=%b/%0d want=1/1",
                     bus.out_valid, bus.out_rd);
        end
        idle(1);
    endtask

    task automatic test_load_use;
        drive(32'h00012283, 32'h104, 12'hB40, 32'h0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00128333;
        bus.in_pc    = 32'h108;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall got=%b/%b want=0/1",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL lu_bubble got=%b/%b want=0/1",
                     bus.out_valid, bus.in_ready);
        end
        q.push_back(mk(32'h00128333, 32'h108, 12'h200, 32'h0, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL lu_second got=%b want=1", bus.out_valid);
        end
        idle(1);
    endtask

    task automatic test_no_bubble;
        drive(32'h00012283, 32'h10C, 12'hB40, 32'h0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00138333;
        bus.in_pc    = 32'h110;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL nb_ready got=%b want=1", bus.in_ready);
        end
        q.push_back(mk(32'h00138333, 32'h110, 12'h200, 32'h0, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL nb_valid got=%b want=1", bus.out_valid);
        end
        idle(2);
    endtask

    task automatic test_stall;
        bus.out_ready = 1'b0;
        drive(32'h12345437, 32'h300, 12'h2C0, 32'h1234_5000, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00138333;
        bus.in_pc    = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
                || bus.out_pc !== 32'h300
                || bus.out_imm !== 32'h1234_5000
                || bus.out_rd !== 5'd8) begin
                bad++;
                $display("FAIL stall_hold c=%0d got=%b/%b/%h/%h want=1/0/300/12345000",
                         i, bus.out_valid, bus.in_ready,
                         bus.out_pc, bus.out_imm);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release got=%b want=1", bus.in_ready);
        end
        q.push_back(mk(32'h00138333, 32'h304, 12'h200, 32'h0, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        idle(2);
    endtask

    task automatic test_flush;
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'hFFB00093;
        bus.in_pc    = 32'h400;
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready got=%b want=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drop got=%b want=0", bus.out_valid);
        end
        idle(1);
    endtask

    task automatic test_imm;
        drive(32'hFE2088E3, 32'h500, 12'h010, 32'hFFFF_FFF0, 1'b0);
        drive(32'hFFDFF06F, 32'h504, 12'h2A0, 32'hFFFF_FFFC, 1'b0);
        drive(32'h001000EF, 32'h508, 12'h2A0, 32'h0000_0800, 1'b0);
        drive(32'hFE20AA23, 32'h50C, 12'h500, 32'hFFFF_FFF4, 1'b0);
        drive(32'h4030D493, 32'h510, 12'h30D, 32'h0000_0403, 1'b0);
        idle(2);
    endtask

    task automatic test_illegal;
        drive(32'h0000007F, 32'h600, 12'h000, 32'h0, 1'b1);
        idle(2);
    endtask

    task automatic test_rv32e(input logic [31:0] inst,
                              input logic ill,
                              input logic [11:0] ctrl);
        bit ok;
        ok = 1'b0;
        bus_e.in_valid = 1'b1;
        bus_e.in_inst  = inst;
        bus_e.in_pc    = 32'h700;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_e.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus_e.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (!ok || bus_e.out_valid !== 1'b1
            || bus_e.out_illegal !== ill) begin
            bad++;
            $display("FAIL e_illegal inst=%h got=%b/%b want=1/%b",
                     inst, bus_e.out_valid, bus_e.out_illegal, ill);
        end
        total++;
        if (bus_e.out_ctrl !== ctrl) begin
            bad++;
            $display("FAIL e_ctrl inst=%h got=%h want=%h",
                     inst, bus_e.out_ctrl, ctrl);
        end
        idle(1);
    endtask

    task automatic test_bypass;
        logic [31:0] want;
        pkt_t p;
`ifdef ID_BYPASS_EN
        want = 32'h1234;
`else
        want = mreg[3];
`endif
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00018233;
        bus.in_pc    = 32'h800;
        wb_we   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h1234;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL byp_ready got=%b want=1", bus.in_ready);
        end
        p = mk(32'h00018233, 32'h800, 12'h200, 32'h0, 1'b0);
        p.rs1 = want;
        q.push_back(p);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wb_we = 1'b0;
        mreg[3] = 32'h1234;
        drive(32'h00018233, 32'h804, 12'h200, 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_end;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_no_bubble();
        test_stall();
        test_flush();
        test_imm();
        test_illegal();
        test_rv32e(32'h00208A33, 1'b1, 12'h000);
        test_rv32e(32'h002082B3, 1'b0, 12'h200);
        test_bypass();
        test_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
